fifo_fwft_ctl: RTL and testbench
================================

Name: fifo_fwft_ctl

Overview:
Parametrised first-word-fall-through FIFO. It is the next generation of the team's fifo_fwft, and is exercised by the same fifo_writer / fifo_fwft_reader bench components. On top of plain FWFT storage it adds:
- fill level output
- programmable almost_full / almost_empty thresholds
- synchronous flush
- sticky overflow / underflow error flags

It sits between producer/consumer streams in the same clock domain.

Parameters:
DATA_WIDTH, 16, width of din/dout.
DEPTH_WIDTH, 4, log2 of total capacity; DEPTH = 2**DEPTH_WIDTH words, output register included.
AF_THR, 2**DEPTH_WIDTH-2, almost_full asserted when level >= AF_THR; legal range 1..DEPTH.
AE_THR, 2, almost_empty asserted when level <= AE_THR; legal range 0..DEPTH-1.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous clear of contents and error flags.
din  in  DATA_WIDTH  write data.
wr_en  in  1  write request.
full  out  1  level == DEPTH.
almost_full  out  1  level >= AF_THR.
dout  out  DATA_WIDTH  head word, valid while empty == 0.
rd_en  in  1  pop head word (acknowledge).
empty  out  1  no valid word on dout.
almost_empty  out  1  level <= AE_THR.
level  out  DEPTH_WIDTH+1  words accepted and not yet popped, including the word on dout.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
Reset (rst low, asynchronous):
- pointers = 0, level = 0, full = 0, empty = 1, almost_empty = 1, almost_full = 0.
- overflow = 0, underflow = 0, dout = 0.
- Takes effect immediately, mid-transfer included; all contents are lost.

Write accept and reject:
- A write is accepted iff wr_en & !full & !flush, where full is the registered value.
- There is no same-cycle pass-through: a write while full is dropped even if rd_en is high in the same cycle.
- A dropped write (wr_en & full & !flush) sets overflow.

Read accept and reject:
- A read is accepted iff rd_en & !empty & !flush.
- rd_en & empty & !flush sets underflow; the FIFO state does not change.

FWFT latency and throughput:
- A write accepted at edge N into an empty FIFO gives level = 1 after edge N.
- dout = data and empty = 0 after edge N+1. empty therefore lags level by one cycle for the first word.
- A read accepted at edge M presents the next word on dout after edge M whenever that word was written at or before edge M-1.
- Sustained one word per cycle each way when level >= 2.

Level arithmetic:
- level_next = level + wr_acc - rd_acc.
- A simultaneous accepted write and read leaves level unchanged.
- level never exceeds DEPTH and never underflows.

Flags:
- full, almost_full and almost_empty are combinational compares on the registered level; they update in the same cycle as level.

Pointers and storage:
- Pointers are DEPTH_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- The memory holds DEPTH-1 words; the output register holds the head word.

Flush:
- Takes priority over wr_en and rd_en.
- After the edge: level = 0, empty = 1, pointers = 0, overflow = 0, underflow = 0. dout holds its last value but is invalid.
- A write or read coinciding with flush is discarded and sets no flag.

Error flags:
- overflow and underflow stay set until flush or reset.

Simultaneous wr_en and rd_en when level == 1 and empty == 0:
- The read is accepted and the write is accepted.
- Next cycle: level = 1, dout = the new word, empty = 0 after a one-cycle bubble (empty = 1 for one cycle).

Decomposition:
Package fifo_pkg:
- clog2 function.
- Default DATA_WIDTH and DEPTH_WIDTH constants.
- Level width derivation, DEPTH_WIDTH+1.

Sub-module fifo_sdp_ram:
- Simple dual-port memory, DATA_WIDTH x 2**DEPTH_WIDTH.
- Synchronous write, synchronous read with read enable, no reset on the array.
- Contains no control logic; pointers, level, prefetch/output register and flags all live in fifo_fwft_ctl.

Test Plan:
All scenarios use DATA_WIDTH=16, DEPTH_WIDTH=4, AF_THR=14, AE_THR=2.
1. Reset: assert rst low mid-stream at level 7 -> immediately level=0, empty=1, full=0, almost_empty=1, overflow=underflow=0; after release, the next write 0x1234 appears on dout two edges later.
2. Single word: write 0xA5A5 at edge N into an empty FIFO -> level=1 after N; empty=0 and dout=0xA5A5 after N+1; rd_en at N+2 -> level=0, empty=1.
3. Fill and overflow:
   - Write 0x0000..0x000F back-to-back -> full=1 at level 16, almost_full=1 from level 14.
   - Extra write 0xFFFF -> dropped, overflow=1.
   - Continuous rd_en returns 0x0000..0x000F in order, one per cycle, with no 0xFFFF.
4. Underflow: rd_en for 3 cycles while empty -> underflow=1, level stays 0; a subsequent write 0x00AA reads back correctly and underflow remains 1.
5. Concurrent traffic: at level 8, run 20 cycles of simultaneous wr_en and rd_en -> level constant 8, almost flags low, output order matches input order.
6. Flush: at level 5, assert flush together with wr_en=1 and din=0xBEEF, with overflow previously set -> after the edge level=0, empty=1, overflow=0; 0xBEEF never appears on dout.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, helper functions and types for the FWFT FIFO family.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_DEPTH_WIDTH = 4;

    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_VALID = 1'b1
    } head_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

    // Level must represent 0..DEPTH inclusive, hence one bit wider than the pointers.
    function automatic int unsigned level_width(input int unsigned depth_width);
        return clog2((32'd1 << depth_width) + 32'd1);
    endfunction

endpackage

// File: rtl/fifo_fwft_ctl_if.sv
// Producer/consumer handshake bundle for fifo_fwft_ctl.
interface fifo_fwft_ctl_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH_WIDTH = DEF_DEPTH_WIDTH
);
    localparam int unsigned LW = level_width(DEPTH_WIDTH);

    logic                  flush;
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_en;
    logic                  empty;
    logic                  almost_empty;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, din, wr_en, rd_en,
        input  full, almost_full, dout, empty, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  flush, din, wr_en, rd_en,
        output full, almost_full, dout, empty, almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable.
module fifo_sdp_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Only the read register is reset; it doubles as the FIFO head register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_fwft_ctl.sv
// First-word-fall-through FIFO controller with level, thresholds, flush and sticky errors.
module fifo_fwft_ctl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH_WIDTH = DEF_DEPTH_WIDTH,
    parameter int unsigned AF_THR      = 2**DEPTH_WIDTH - 2,
    parameter int unsigned AE_THR      = 2
) (
    input  logic           clk,
    input  logic           rst,
    fifo_fwft_ctl_if.slave bus
);

    localparam int unsigned   LW      = level_width(DEPTH_WIDTH);
    localparam int unsigned   DEPTH   = 2**DEPTH_WIDTH;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THR);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THR);

    logic [DEPTH_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [DEPTH_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
    logic [LW-1:0]          level_q, level_nxt;
    logic [LW-1:0]          mem_cnt;
    head_state_t            head_q, head_nxt;
    logic                   ovf_q, ovf_nxt;
    logic                   udf_q, udf_nxt;
    logic                   full_w, empty_w;
    logic                   wr_acc, rd_acc, load;

    assign full_w  = (level_q == DEPTH_L);
    assign empty_w = (head_q == HEAD_EMPTY);
    // Words held in memory behind the head; all were written at an earlier edge.
    assign mem_cnt = level_q - LW'(head_q == HEAD_VALID);

    always_comb begin
        wr_acc     = bus.wr_en & ~full_w & ~bus.flush;
        rd_acc     = bus.rd_en & ~empty_w & ~bus.flush;
        load       = (mem_cnt != '0) & (empty_w | rd_acc) & ~bus.flush;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level_q;
        head_nxt   = head_q;
        ovf_nxt    = ovf_q;
        udf_nxt    = udf_q;
        if (bus.flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
            head_nxt   = HEAD_EMPTY;
            ovf_nxt    = 1'b0;
            udf_nxt    = 1'b0;
        end else begin
            wr_ptr_nxt = wr_ptr + DEPTH_WIDTH'(wr_acc);
            rd_ptr_nxt = rd_ptr + DEPTH_WIDTH'(load);
            level_nxt  = level_q + LW'(wr_acc) - LW'(rd_acc);
            if (load)        head_nxt = HEAD_VALID;
            else if (rd_acc) head_nxt = HEAD_EMPTY;
            ovf_nxt = ovf_q | (bus.wr_en & full_w);
            udf_nxt = udf_q | (bus.rd_en & empty_w);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            head_q  <= HEAD_EMPTY;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            level_q <= level_nxt;
            head_q  <= head_nxt;
            ovf_q   <= ovf_nxt;
            udf_q   <= udf_nxt;
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.din),
        .rd_en   (load),
        .rd_addr (rd_ptr),
        .rd_data (bus.dout)
    );

    assign bus.full         = full_w;
    assign bus.almost_full  = (level_q >= AF_L);
    assign bus.almost_empty = (level_q <= AE_L);
    assign bus.empty        = empty_w;
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_fwft_ctl.sv
// Randomised and directed bench for fifo_fwft_ctl against a queue-based FWFT model.
module tb_fifo_fwft_ctl;

    localparam int unsigned DW  = 16;
    localparam int unsigned DPW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fifo_fwft_ctl_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DPW)) bus ();

    fifo_fwft_ctl #(
        .DATA_WIDTH  (DW),
        .DEPTH_WIDTH (DPW),
        .AF_THR      (14),
        .AE_THR      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: queue of accepted words stamped with the edge that wrote them.
    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } ent_t;

    ent_t          q[$];
    ent_t          ent;
    bit            shown  = 1'b0;
    logic [DW-1:0] m_dout = '0;
    bit            m_ovf  = 1'b0;
    bit            m_udf  = 1'b0;
    int            edge_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                shown  = 1'b0;
                m_dout = '0;
                m_ovf  = 1'b0;
                m_udf  = 1'b0;
            end else begin
                edge_no++;
                if (bus.flush) begin
                    q.delete();
                    shown = 1'b0;
                    m_ovf = 1'b0;
                    m_udf = 1'b0;
                end else begin
                    bit wacc, racc;
                    wacc = bus.wr_en && (q.size() < 16);
                    racc = bus.rd_en && shown;
                    if (bus.wr_en && q.size() == 16) m_ovf = 1'b1;
                    if (bus.rd_en && !shown)         m_udf = 1'b1;
                    if (racc) begin
                        void'(q.pop_front());
                        shown = 1'b0;
                    end
                    if (!shown && q.size() > 0 && q[0].e < edge_no) begin
                        shown  = 1'b1;
                        m_dout = q[0].d;
                    end
                    if (wacc) begin
                        ent.d = bus.din;
                        ent.e = edge_no;
                        q.push_back(ent);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                chk("m_level", 32'(bus.level), 32'(q.size()));
                chk("m_full", 32'(bus.full), 32'(q.size() == 16));
                chk("m_almost_full", 32'(bus.almost_full), 32'(q.size() >= 14));
                chk("m_almost_empty", 32'(bus.almost_empty), 32'(q.size() <= 2));
                chk("m_empty", 32'(bus.empty), 32'(!shown));
                chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
                chk("m_underflow", 32'(bus.underflow), 32'(m_udf));
                if (shown) chk("m_dout", 32'(bus.dout), 32'(m_dout));
            end
        end
    end

    task automatic cyc(input bit we, input logic [DW-1:0] d, input bit re, input bit fl);
        @(negedge clk);
        bus.wr_en = we;
        bus.din   = d;
        bus.rd_en = re;
        bus.flush = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_level"}, 32'(bus.level), 0);
        chk({tag, "_empty"}, 32'(bus.empty), 1);
        chk({tag, "_full"}, 32'(bus.full), 0);
        chk({tag, "_ae"}, 32'(bus.almost_empty), 1);
        chk({tag, "_af"}, 32'(bus.almost_full), 0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 0);
        chk({tag, "_udf"}, 32'(bus.underflow), 0);
        chk({tag, "_dout"}, 32'(bus.dout), 0);
    endtask

    logic [DW-1:0] t5q[$];
    logic [DW-1:0] w;

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        bus.din   = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b1;

        // Single word latency
        cyc(1, 16'hA5A5, 0, 0);
        chk("sw_level", 32'(bus.level), 1);
        chk("sw_empty_lag", 32'(bus.empty), 1);
        cyc(0, '0, 0, 0);
        chk("sw_empty", 32'(bus.empty), 0);
        chk("sw_dout", 32'(bus.dout), 32'h A5A5);
        cyc(0, '0, 1, 0);
        chk("sw_rd_level", 32'(bus.level), 0);
        chk("sw_rd_empty", 32'(bus.empty), 1);
        cyc(0, '0, 0, 0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1, 16'(i), 0, 0);
            chk("fill_level", 32'(bus.level), 32'(i + 1));
            chk("fill_af", 32'(bus.almost_full), 32'(i + 1 >= 14));
            chk("fill_full", 32'(bus.full), 32'(i == 15));
        end
        cyc(1, 16'hFFFF, 0, 0);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_level", 32'(bus.level), 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_dout", 32'(bus.dout), 32'(i));
            chk("drain_empty", 32'(bus.empty), 0);
            cyc(0, '0, 1, 0);
        end
        chk("drain_level", 32'(bus.level), 0);
        chk("drain_end_empty", 32'(bus.empty), 1);
        cyc(0, '0, 0, 0);

        // Underflow
        chk("udf_pre", 32'(bus.underflow), 0);
        repeat (3) cyc(0, '0, 1, 0);
        chk("udf_flag", 32'(bus.underflow), 1);
        chk("udf_level", 32'(bus.level), 0);
        cyc(1, 16'h00AA, 0, 0);
        cyc(0, '0, 0, 0);
        chk("udf_dout", 32'(bus.dout), 32'h00AA);
        chk("udf_sticky", 32'(bus.underflow), 1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        // Concurrent traffic at level 8
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            t5q.push_back(w);
            cyc(1, w, 0, 0);
        end
        cyc(0, '0, 0, 0);
        chk("cc_start_level", 32'(bus.level), 8);
        for (int i = 0; i < 20; i++) begin
            chk("cc_order", 32'(bus.dout), 32'(t5q[0]));
            void'(t5q.pop_front());
            w = 16'($urandom);
            t5q.push_back(w);
            cyc(1, w, 1, 0);
            chk("cc_level", 32'(bus.level), 8);
            chk("cc_af", 32'(bus.almost_full), 0);
            chk("cc_ae", 32'(bus.almost_empty), 0);
        end

        // Flush at level 5 with overflow set and a coinciding write
        repeat (3) cyc(0, '0, 1, 0);
        chk("fl_pre_level", 32'(bus.level), 5);
        chk("fl_pre_ovf", 32'(bus.overflow), 1);
        cyc(1, 16'hBEEF, 0, 1);
        chk("fl_level", 32'(bus.level), 0);
        chk("fl_empty", 32'(bus.empty), 1);
        chk("fl_ovf", 32'(bus.overflow), 0);
        chk("fl_udf", 32'(bus.underflow), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, 0, 0);
            chk("fl_no_beef", 32'(bus.dout != 16'hBEEF), 1);
            chk("fl_stay_empty", 32'(bus.empty), 1);
        end

        // Asynchronous reset mid-stream at level 7 with underflow set
        cyc(0, '0, 1, 0);
        for (int i = 0; i < 7; i++) cyc(1, 16'(16'h0100 + i), 0, 0);
        chk("ar_pre_level", 32'(bus.level), 7);
        chk("ar_pre_udf", 32'(bus.underflow), 1);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.din   = 16'h7777;
        #1 rst = 1'b0;
        #1 chk_reset_state("ar");
        bus.wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc(1, 16'h1234, 0, 0);
        chk("ar_w_empty", 32'(bus.empty), 1);
        cyc(0, '0, 0, 0);
        chk("ar_w_dout", 32'(bus.dout), 32'h1234);
        chk("ar_w_valid", 32'(bus.empty), 0);
        cyc(0, '0, 1, 0);

        // Random traffic alternating fill-biased and drain-biased segments
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 60; c++) begin
                int unsigned pw;
                pw = (seg % 2 == 0) ? 75 : 25;
                cyc($urandom_range(0, 99) < pw, 16'($urandom),
                    $urandom_range(0, 99) < (100 - pw), $urandom_range(0, 99) < 2);
            end
        end
        repeat (3) cyc(0, '0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
